i3c_target_daa_responder: RTL
=============================

// Module: i3c_target_daa_responder
// PURPOSE
//  Target-side ENTDAA responder for the SDR I3C bus: the peer of i3c_controller_top's DAA sequence.
//  Detects START/Sr/STOP and ACKs the 7E/W broadcast. Checks the ENTDAA CCC (0x07) and its T-bit.
//  ACKs 7E/R, then arbitrates its 64-bit PID/BCR/DCR. Receives the assigned 7-bit dynamic address + parity and ACKs it.
//  Sits in the target model used by the DAA benches. SDA is open-drain: the block only pulls low or releases.
// PARAMETERS
//  P_PID  48'h0000_0000_0001  provisional ID, sent MSB first
//  P_BCR  8'h00               bus characteristics register, sent after PID
//  P_DCR  8'h00               device characteristics register, sent after BCR
// PORTS
//  i_sdr_clk        in   1  system clock; oversamples SCL/SDA (>=4 clk per SCL phase)
//  i_sdr_rst_n      in   1  asynchronous active-low reset
//  i_scl            in   1  bus SCL, already synchronised to i_sdr_clk
//  i_sda            in   1  bus SDA (resolved wired-AND value), already synchronised
//  o_sda_low        out  1  1 = pull SDA low, 0 = release (pull-up)
//  o_dyn_addr       out  7  assigned dynamic address
//  o_addr_valid     out  1  sticky: dynamic address assigned
//  o_daa_done       out  1  1-clk pulse when the address ACK bit ends
//  o_arb_lost       out  1  1-clk pulse on arbitration loss
// BEHAVIOUR
//  Reset (async): state=IDLE, o_sda_low=0, o_dyn_addr=0, o_addr_valid=0, pulses=0, bit counter=0.
//  Edge detect: previous i_scl/i_sda are registered. Rise/fall are single-clk strobes.
//  START/Sr: SDA falls while SCL=1. STOP: SDA rises while SCL=1. Data is sampled on SCL rise.
//  o_sda_low is updated 1 clk after SCL fall. It never changes while SCL=1.
//  All outputs are registered.
//  State flow:
//   IDLE   -START->  HDR
//   HDR    8 bits; ==0xFC (7E/W) -> W_ACK; any other value -> IDLE (ignored)
//   W_ACK  drive low from SCL fall after bit 8 to SCL fall after bit 9 -> CCC
//   CCC    9 bits; D=0x07 and T=~^D (odd parity) -> WAIT_SR; otherwise -> IDLE
//   WAIT_SR  -Sr-> RHDR
//   RHDR   8 bits; ==0xFD (7E/R) and !o_addr_valid -> R_ACK; else -> WAIT_SR (no ACK)
//   R_ACK  ACK as in W_ACK -> ARB
//   ARB    64 bits {P_PID,P_BCR,P_DCR}, MSB first
//          - on each SCL fall: o_sda_low = ~bit
//          - on SCL rise, bit=1 and i_sda=0: lost -> release, pulse o_arb_lost, WAIT_SR
//          - after bit 64: release -> ADDR
//   ADDR   8 bits {A[6:0],P}
//          - P==~^A: latch o_dyn_addr=A -> A_ACK
//          - else: no ACK (released) -> WAIT_SR; the controller retries
//   A_ACK  ACK; at SCL fall ending the ACK: o_addr_valid=1, pulse o_daa_done -> WAIT_SR
//  STOP in any state -> IDLE, o_sda_low=0.
//   o_dyn_addr/o_addr_valid hold through STOP and are cleared only by reset.
//  START/Sr seen mid-byte (other than WAIT_SR): abort, release, bit counter=0, -> HDR.
//  Once o_addr_valid=1, later 7E/R headers are not ACKed. The target sits out further DAA rounds.
//  Bit counter is 7 bits: 0..63 in ARB, 0..8 elsewhere. It is cleared on every state entry.
//  Simultaneous STOP and SCL edge cannot occur (SCL=1 for STOP). STOP has priority over all data events.
// TESTING
//  1 START, 0xFC, 0x07+T=0, Sr, 0xFD; bus-high during ARB
//    -> ACKs at both ACK slots; SDA follows P_PID/BCR/DCR bits
//  2 Continue case 1 with address 0x08, P=0 (~^0x08)
//    -> ACK; o_dyn_addr=0x08; o_addr_valid=1; one o_daa_done pulse
//  3 P_PID=48'h8000_0000_0000; competing target forces SDA=0 on ARB bit 0
//    -> o_arb_lost pulse, o_sda_low=0 for all later bits, no address latched
//  4 CCC 0x07 with T=1 (bad parity), or header 0xFE
//    -> no ACK, state IDLE, outputs unchanged
//  5 Address 0x09 with P=0 (bad parity) -> no ACK, o_addr_valid stays 0
//    Retry after Sr with 0x09, P=1 -> ACK, o_dyn_addr=0x09
//  6 i_sdr_rst_n low mid-ARB with o_sda_low=1 -> o_sda_low=0 at once; all outputs at reset values
//    Second DAA after assignment -> 7E/R not ACKed

Source files
------------

// File: rtl/i3c_target_daa_responder.sv
// I3C SDR target-side ENTDAA responder: ACKs the 7E/W broadcast and the ENTDAA CCC,
// arbitrates {PID,BCR,DCR} on 7E/R, then accepts a parity-checked dynamic address.
module i3c_target_daa_responder #(
    parameter logic [47:0] P_PID = 48'h0000_0000_0001,
    parameter logic [7:0]  P_BCR = 8'h00,
    parameter logic [7:0]  P_DCR = 8'h00
) (
    input  logic       i_sdr_clk,
    input  logic       i_sdr_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_low,
    output logic [6:0] o_dyn_addr,
    output logic       o_addr_valid,
    output logic       o_daa_done,
    output logic       o_arb_lost
);

    localparam logic [63:0] ARB_WORD = {P_PID, P_BCR, P_DCR};

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_HDR     = 4'd1;
    localparam logic [3:0] S_W_ACK   = 4'd2;
    localparam logic [3:0] S_CCC     = 4'd3;
    localparam logic [3:0] S_WAIT_SR = 4'd4;
    localparam logic [3:0] S_RHDR    = 4'd5;
    localparam logic [3:0] S_R_ACK   = 4'd6;
    localparam logic [3:0] S_ARB     = 4'd7;
    localparam logic [3:0] S_ADDR    = 4'd8;
    localparam logic [3:0] S_A_ACK   = 4'd9;

    logic       scl_q, sda_q;
    logic [3:0] state;
    logic [6:0] cnt;
    logic [7:0] shreg;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;
    logic [5:0] arb_idx, nxt_idx;
    logic       arb_bit, arb_nxt;

    always_comb begin
        scl_rise  = i_scl & ~scl_q;
        scl_fall  = ~i_scl & scl_q;
        start_det = scl_q & i_scl & sda_q & ~i_sda;
        stop_det  = scl_q & i_scl & ~sda_q & i_sda;
        // byte completed by the current SCL rise
        rx_byte   = {shreg[6:0], i_sda};
        arb_idx   = ~cnt[5:0];
        nxt_idx   = ~(cnt[5:0] + 6'd1);
        arb_bit   = ARB_WORD[arb_idx];
        arb_nxt   = ARB_WORD[nxt_idx];
    end

    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            scl_q        <= 1'b1;
            sda_q        <= 1'b1;
            state        <= S_IDLE;
            cnt          <= '0;
            shreg        <= '0;
            o_sda_low    <= 1'b0;
            o_dyn_addr   <= '0;
            o_addr_valid <= 1'b0;
            o_daa_done   <= 1'b0;
            o_arb_lost   <= 1'b0;
        end else begin
            scl_q      <= i_scl;
            sda_q      <= i_sda;
            o_daa_done <= 1'b0;
            o_arb_lost <= 1'b0;
            if (stop_det) begin
                state     <= S_IDLE;
                cnt       <= '0;
                o_sda_low <= 1'b0;
            end else if (start_det) begin
                cnt       <= '0;
                o_sda_low <= 1'b0;
                state     <= (state == S_WAIT_SR) ? S_RHDR : S_HDR;
            end else begin
                if (scl_rise) shreg <= rx_byte;
                case (state)
                    S_HDR, S_RHDR: if (scl_rise) begin
                        if (cnt == 7'd7) begin
                            cnt <= '0;
                            if (state == S_HDR)
                                state <= (rx_byte == 8'hFC) ? S_W_ACK : S_IDLE;
                            else
                                state <= (rx_byte == 8'hFD && !o_addr_valid) ? S_R_ACK : S_WAIT_SR;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                    S_CCC: if (scl_rise) begin
                        if (cnt == 7'd8) begin
                            cnt   <= '0;
                            state <= (shreg == 8'h07 && i_sda == ~^shreg) ? S_WAIT_SR : S_IDLE;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                    // First fall after the byte pulls SDA low, the second ends the ACK.
                    S_W_ACK, S_R_ACK, S_A_ACK: if (scl_fall) begin
                        if (cnt == 7'd0) begin
                            cnt       <= 7'd1;
                            o_sda_low <= 1'b1;
                        end else begin
                            cnt       <= '0;
                            o_sda_low <= 1'b0;
                            if (state == S_W_ACK) begin
                                state <= S_CCC;
                            end else if (state == S_R_ACK) begin
                                state     <= S_ARB;
                                o_sda_low <= ~ARB_WORD[63];
                            end else begin
                                state        <= S_WAIT_SR;
                                o_addr_valid <= 1'b1;
                                o_daa_done   <= 1'b1;
                            end
                        end
                    end
                    S_ARB: begin
                        if (scl_rise && arb_bit && !i_sda) begin
                            cnt        <= '0;
                            o_sda_low  <= 1'b0;
                            o_arb_lost <= 1'b1;
                            state      <= S_WAIT_SR;
                        end else if (scl_fall) begin
                            if (cnt == 7'd63) begin
                                cnt       <= '0;
                                o_sda_low <= 1'b0;
                                state     <= S_ADDR;
                            end else begin
                                cnt       <= cnt + 7'd1;
                                o_sda_low <= ~arb_nxt;
                            end
                        end
                    end
                    S_ADDR: if (scl_rise) begin
                        if (cnt == 7'd7) begin
                            cnt <= '0;
                            if (i_sda == ~^shreg[6:0]) begin
                                o_dyn_addr <= shreg[6:0];
                                state      <= S_A_ACK;
                            end else begin
                                state <= S_WAIT_SR;
                            end
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
